fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_npc_calc.sv | 30 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch path: FSM states, next-PC select codes,
// the reset instruction and the decoder-visible instruction field layout.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // Next-PC select driven by the decoder alongside the consumed instruction.
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npc_op_e;

  // addi x0, x0, 0 -- what the instruction register holds out of reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Control field positions inside an instruction word.
  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection with alignment fix-up and error reporting.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic [31:0] npc,
  output logic        op_err,
  output logic        misalign
);

  logic [31:0] raw_npc;

  // Select the raw target, then force word alignment when bit 1 is set.
  always_comb begin
    raw_npc = pc + 32'd4;
    op_err  = 1'b0;
    case (npc_op)
      NPC_PLUS4:            raw_npc = pc + 32'd4;
      NPC_BRANCH, NPC_JUMP: raw_npc = pc + imm;
      NPC_JALR:             raw_npc = alu_out & ~32'd1;
      default:              op_err  = 1'b1;
    endcase
    misalign = raw_npc[1];
    npc      = misalign ? {raw_npc[31:2], 2'b00} : raw_npc;
  end

endmodule : npc_calc

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at the current PC, holds it for
// the decoder, and steps the PC from the decoder's next-PC select on consume.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] pc_out,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        fetch_timeout,
  output logic        npc_err,
  output logic        misalign
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_timeout_q, fetch_timeout_d;
  logic             npc_err_q, npc_err_d;
  logic             misalign_q, misalign_d;

  logic [31:0]      npc;
  logic             npc_op_err;
  logic             npc_misalign;

  npc_calc u_npc_calc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .imm      (imm),
    .alu_out  (alu_out),
    .npc      (npc),
    .op_err   (npc_op_err),
    .misalign (npc_misalign)
  );

  // Next-state, wait counter, sticky flags and the request/valid handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    wait_cnt_d      = wait_cnt_q;
    fetch_timeout_d = fetch_timeout_q;
    npc_err_d       = npc_err_q;
    misalign_d      = misalign_q;
    imem_req        = 1'b0;
    instr_valid     = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d    = S_REQ;
        wait_cnt_d = '0;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d    = imem_rdata;
          wait_cnt_d = '0;
          state_d    = S_HOLD;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Flag the slow memory but keep requesting the same address.
          fetch_timeout_d = 1'b1;
          wait_cnt_d      = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d       = npc;
          npc_err_d  = npc_err_q | npc_op_err;
          misalign_d = misalign_q | npc_misalign;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State register with synchronous reset; reset wins over any pending ack.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= S_BOOT;
      pc_q            <= RESET_PC;
      instr_q         <= NOP_INSTR;
      wait_cnt_q      <= '0;
      fetch_timeout_q <= 1'b0;
      npc_err_q       <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      wait_cnt_q      <= wait_cnt_d;
      fetch_timeout_q <= fetch_timeout_d;
      npc_err_q       <= npc_err_d;
      misalign_q      <= misalign_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc_out        = pc_q;
  assign instr         = instr_q;
  assign op            = instr_q[OP_LSB +: OP_W];
  assign funct3        = instr_q[FUNCT3_LSB +: FUNCT3_W];
  assign funct7        = instr_q[FUNCT7_LSB +: FUNCT7_W];
  assign fetch_timeout = fetch_timeout_q;
  assign npc_err       = npc_err_q;
  assign misalign      = misalign_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// fetch/consume stream compared against a behavioural PC model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc_out;
  logic [2:0]  npc_op;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        fetch_timeout;
  logic        npc_err;
  logic        misalign;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .pc_out        (pc_out),
    .npc_op        (npc_op),
    .imm           (imm),
    .alu_out       (alu_out),
    .fetch_timeout (fetch_timeout),
    .npc_err       (npc_err),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_err, m_mis, m_to;
  logic [31:0] m_instr;

  // Next PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [2:0] sel,
                                          input logic [31:0] imm_v, input logic [31:0] alu_v,
                                          output logic bad, output logic odd);
    logic [31:0] t;
    bad = 1'b0;
    case (sel)
      3'd0:       t = pc + 32'd4;
      3'd1, 3'd2: t = pc + imm_v;
      3'd4:       t = alu_v - (alu_v % 32'd2);
      default: begin
        t   = pc + 32'd4;
        bad = 1'b1;
      end
    endcase
    odd = (t % 32'd4) >= 32'd2;
    if (odd) t = t - (t % 32'd4);
    return t;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Two reset cycles; leaves the DUT just released (still in boot).
  task automatic apply_reset();
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_pc = 32'h0; m_err = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_instr = 32'h0000_0013;
  endtask

  // Wait `delay` request cycles without ack, then return `data`.
  task automatic do_fetch(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      n_tests++;
      if ({imem_req, instr_valid, imem_addr} !== {2'b10, m_pc}) begin
        n_fail++;
        $display("FAIL fetch_wait: req/valid/addr=%b%b/%h expected 10/%h", imem_req, instr_valid, imem_addr, m_pc);
      end
      tick();
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, m_pc}) begin
      n_fail++;
      $display("FAIL fetch_req: req/addr=%b/%h expected 1/%h", imem_req, imem_addr, m_pc);
    end
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    m_instr = data;
    n_tests++;
    if ({instr_valid, imem_req, instr, pc_out} !== {2'b10, data, m_pc}) begin
      n_fail++;
      $display("FAIL fetch_hold: valid/req/instr/pc=%b%b/%h/%h expected 10/%h/%h", instr_valid, imem_req, instr, pc_out, data, m_pc);
    end
    n_tests++;
    if ({funct7, funct3, op} !== {data[31:25], data[14:12], data[6:0]}) begin
      n_fail++;
      $display("FAIL fetch_fields: f7/f3/op=%h/%h/%h for instr %h", funct7, funct3, op, data);
    end
  endtask

  // Consume the held instruction with the given next-PC select.
  task automatic do_consume(input logic [2:0] sel, input logic [31:0] imm_v, input logic [31:0] alu_v);
    logic bad, odd;
    logic [31:0] nxt;
    nxt = ref_npc(m_pc, sel, imm_v, alu_v, bad, odd);
    instr_ready = 1'b1; npc_op = sel; imm = imm_v; alu_out = alu_v;
    tick();
    instr_ready = 1'b0; npc_op = 3'($urandom); imm = $urandom; alu_out = $urandom;
    m_pc = nxt; m_err = m_err | bad; m_mis = m_mis | odd;
    n_tests++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, m_pc}) begin
      n_fail++;
      $display("FAIL consume_addr: req/valid/addr=%b%b/%h expected 10/%h", imem_req, instr_valid, imem_addr, m_pc);
    end
    n_tests++;
    if ({npc_err, misalign, fetch_timeout} !== {m_err, m_mis, m_to}) begin
      n_fail++;
      $display("FAIL consume_flags: err/mis/to=%b%b%b expected %b%b%b", npc_err, misalign, fetch_timeout, m_err, m_mis, m_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom; instr_ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({imem_req, instr_valid, fetch_timeout, npc_err, misalign} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/valid/to/err/mis=%b%b%b%b%b expected 00000", imem_req, instr_valid, fetch_timeout, npc_err, misalign);
    end
    n_tests++;
    if ({pc_out, imem_addr, instr} !== {32'h0, 32'h0, 32'h0000_0013}) begin
      n_fail++;
      $display("FAIL reset_regs: pc/addr/instr=%h/%h/%h expected 0/0/00000013", pc_out, imem_addr, instr);
    end
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    m_pc = 32'h0; m_err = 1'b0; m_mis = 1'b0; m_to = 1'b0;
  endtask

  // Ack already high when the first request appears: one-cycle fetch.
  task automatic test_first_fetch();
    logic [31:0] data;
    data = $urandom;
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    n_tests++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL first_req: req/valid/addr=%b%b/%h expected 10/00000000", imem_req, instr_valid, imem_addr);
    end
    tick();
    imem_ack = 1'b0;
    n_tests++;
    if ({instr_valid, imem_req, instr, pc_out} !== {2'b10, data, 32'h0}) begin
      n_fail++;
      $display("FAIL first_valid: valid/req/instr/pc=%b%b/%h/%h expected 10/%h/00000000", instr_valid, imem_req, instr, pc_out, data);
    end
    m_instr = data;
  endtask

  task automatic test_npc_directed();
    apply_reset(); tick();
    do_fetch(0, $urandom);
    do_consume(3'b100, $urandom, 32'h20);
    do_fetch(1, $urandom);
    do_consume(3'b001, 32'hFFFF_FFF8, $urandom);
    n_tests++;
    if ({imem_addr, misalign} !== {32'h18, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_back: addr/mis=%h/%b expected 00000018/0", imem_addr, misalign);
    end
    do_fetch(0, $urandom);
    do_consume(3'b100, $urandom, 32'h101);
    n_tests++;
    if ({imem_addr, misalign} !== {32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL jalr_bit0: addr/mis=%h/%b expected 00000100/0", imem_addr, misalign);
    end
    do_fetch(2, $urandom);
    do_consume(3'b100, $urandom, 32'h106);
    n_tests++;
    if ({imem_addr, misalign} !== {32'h104, 1'b1}) begin
      n_fail++;
      $display("FAIL jalr_misalign: addr/mis=%h/%b expected 00000104/1", imem_addr, misalign);
    end
    do_fetch(0, $urandom);
    do_consume(3'b000, $urandom, $urandom);
    n_tests++;
    if ({imem_addr, misalign} !== {32'h108, 1'b1}) begin
      n_fail++;
      $display("FAIL misalign_sticky: addr/mis=%h/%b expected 00000108/1", imem_addr, misalign);
    end
    do_fetch(0, $urandom);
    do_consume(3'b011, $urandom, $urandom);
    n_tests++;
    if ({imem_addr, npc_err} !== {32'h10C, 1'b1}) begin
      n_fail++;
      $display("FAIL bad_npc_op: addr/err=%h/%b expected 0000010c/1", imem_addr, npc_err);
    end
    do_fetch(0, $urandom);
    do_consume(3'b010, 32'h10, $urandom);
    n_tests++;
    if (imem_addr !== 32'h11C) begin
      n_fail++;
      $display("FAIL jal: addr=%h expected 0000011c", imem_addr);
    end
    do_fetch(0, $urandom);
  endtask

  task automatic test_wrap();
    apply_reset(); tick();
    do_fetch(0, $urandom);
    do_consume(3'b100, $urandom, 32'hFFFF_FFFC);
    do_fetch(0, $urandom);
    do_consume(3'b000, $urandom, $urandom);
    n_tests++;
    if ({imem_addr, npc_err, misalign, fetch_timeout} !== {32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL wrap: addr/flags=%h/%b%b%b expected 00000000/000", imem_addr, npc_err, misalign, fetch_timeout);
    end
    do_fetch(0, $urandom);
  endtask

  task automatic test_timeout();
    apply_reset(); tick();
    for (int i = 1; i <= 16; i++) begin
      n_tests++;
      if ({imem_req, fetch_timeout, imem_addr} !== {2'b10, 32'h0}) begin
        n_fail++;
        $display("FAIL timeout_early: cycle %0d req/to/addr=%b%b/%h expected 10/00000000", i, imem_req, fetch_timeout, imem_addr);
      end
      tick();
    end
    m_to = 1'b1;
    n_tests++;
    if ({imem_req, fetch_timeout, imem_addr} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_flag: req/to/addr=%b%b/%h expected 11/00000000", imem_req, fetch_timeout, imem_addr);
    end
    do_fetch(3, $urandom);
    do_consume(3'b000, $urandom, $urandom);
    do_fetch(0, $urandom);
  endtask

  // Decoder stalls in hold while acks and next-PC inputs toggle.
  task automatic test_stall();
    logic [31:0] data;
    apply_reset(); tick();
    data = $urandom;
    do_fetch(1, data);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      npc_op = 3'($urandom); imm = $urandom; alu_out = $urandom;
      tick();
      n_tests++;
      if ({instr_valid, imem_req, instr, pc_out} !== {2'b10, data, m_pc}) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d valid/req/instr/pc=%b%b/%h/%h expected 10/%h/%h", i, instr_valid, imem_req, instr, pc_out, data, m_pc);
      end
    end
    imem_ack = 1'b0;
    do_consume(3'b000, $urandom, $urandom);
  endtask

  // Reset lands in the middle of a request with an ack in the same cycle.
  task automatic test_reset_mid_fetch();
    apply_reset(); tick();
    do_fetch(0, $urandom);
    do_consume(3'b110, $urandom, $urandom);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    m_pc = 32'h0; m_err = 1'b0; m_mis = 1'b0; m_to = 1'b0;
    n_tests++;
    if ({imem_req, instr_valid, npc_err, instr, pc_out} !== {3'b000, 32'h0000_0013, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_fetch: req/valid/err/instr/pc=%b%b%b/%h/%h expected 000/00000013/00000000", imem_req, instr_valid, npc_err, instr, pc_out);
    end
    tick();
    n_tests++;
    if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_refetch: req/valid/addr=%b%b/%h expected 10/00000000", imem_req, instr_valid, imem_addr);
    end
    do_fetch(0, $urandom);
  endtask

  task automatic test_random();
    logic [31:0] r_imm;
    logic [2:0]  sel;
    int          pick;
    apply_reset(); tick();
    for (int n = 0; n < 60; n++) begin
      do_fetch(int'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) begin
        tick();
        n_tests++;
        if ({instr_valid, instr, pc_out} !== {1'b1, m_instr, m_pc}) begin
          n_fail++;
          $display("FAIL rand_stall: valid/instr/pc=%b/%h/%h expected 1/%h/%h", instr_valid, instr, pc_out, m_instr, m_pc);
        end
      end
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1, 2: sel = 3'd0;
        3, 4:    sel = 3'd1;
        5, 6:    sel = 3'd2;
        7, 8:    sel = 3'd4;
        default: sel = (3'($urandom) | 3'b011) & 3'b111;
      endcase
      r_imm = $urandom;
      r_imm = r_imm - (r_imm % 32'd2);
      do_consume(sel, r_imm, $urandom);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    npc_op = '0; imm = '0; alu_out = '0;
    m_pc = '0; m_err = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_instr = 32'h0000_0013;
    tick();
    test_reset();
    test_first_fetch();
    test_npc_directed();
    test_wrap();
    test_timeout();
    test_stall();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
